led_pattern_arbiter: RTL and testbench
======================================

LED_PATTERN_ARBITER -- requirements
Module: led_pattern_arbiter

Interface
REQ-001 The block SHALL have parameter DIV_COUNT, default 5000, meaning the number of CLOCK_50 cycles per pattern bit slot (valid range 2..2^20).
REQ-002 The block SHALL have parameter GAP_SLOTS, default 2, meaning the number of dark slots after each pattern (valid range 1..15).
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 2 bits: level request per requester; bit i is requester i.
REQ-006 The block SHALL have port pat0, input, 8 bits: requester 0 blink pattern, played MSB first.
REQ-007 The block SHALL have port pat1, input, 8 bits: requester 1 blink pattern, played MSB first.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot grant, held high from grant until done.
REQ-009 The block SHALL have port done, output, 2 bits: single-cycle pulse on bit i when requester i's pattern and gap are complete.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The block SHALL have port LED, output, 1 bit: the shared LED drive, high means lit.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, PLAY and GAP.
REQ-013 In IDLE with req != 0, the next edge SHALL go to PLAY, set gnt, latch the granted pattern into an internal register, set the slot index to 7, and clear the slot counter.
REQ-014 Arbitration SHALL be round-robin: with both requests high, the grant goes to the requester not granted last; after reset, requester 0 wins the first tie.
REQ-015 With a single request high, that requester SHALL be granted regardless of the round-robin pointer.
REQ-016 The slot counter SHALL count 0..DIV_COUNT-1 and wrap to 0; the slot ends on the cycle the count equals DIV_COUNT-1.
REQ-017 In PLAY, LED SHALL equal pattern_reg[slot index]; the index decrements at each slot end.
REQ-018 At the end of the index-0 slot, the FSM SHALL go to GAP, drive LED to 0, and load the gap counter with GAP_SLOTS.
REQ-019 In GAP, the gap counter SHALL decrement at each slot end; at the slot end where it reaches 0, the FSM SHALL go to IDLE, pulse done[i] for 1 cycle, deassert gnt, and update the round-robin pointer.
REQ-020 Grant-to-done latency SHALL be exactly (8+GAP_SLOTS)*DIV_COUNT cycles.
REQ-021 Changes to req or pat* after the grant SHALL be ignored until IDLE is re-entered; a dropped request does not abort playback.
REQ-022 A request still high when the FSM returns to IDLE SHALL be re-arbitrated normally, so back-to-back service alternates when both requests are high.
REQ-023 LED SHALL be 0 in IDLE and in GAP; gnt SHALL be 0 in IDLE; gnt and done SHALL each be one-hot or zero at all times.
REQ-024 The slot counter SHALL be sized as clog2(DIV_COUNT) bits with no overflow past DIV_COUNT-1.

Reset
REQ-025 While reset is low, the block SHALL be in IDLE with gnt=0, done=0, busy=0, LED=0, all counters=0, pattern_reg=0, and the round-robin pointer favouring requester 0.
REQ-026 Reset asserted mid-PLAY or mid-GAP SHALL abort immediately with no done pulse.
REQ-027 After reset is released, the block SHALL arbitrate on the first rising edge.

Structure
REQ-028 The FSM state encoding and the default constants for DIV_COUNT and GAP_SLOTS SHALL live in a shared package, led_pkg.
REQ-029 The slot divider SHALL be one sub-module, slot_tick, with inputs clear and enable and a single-cycle tick output.

Verification (DIV_COUNT=4, GAP_SLOTS=2)
REQ-030 Scenario: req=01, pat0=8'b1010_0001 -> gnt=01 on the next edge; LED reads 1,0,1,0,0,0,0,1, each held 4 cycles; then 8 cycles dark; done[0] pulses 40 cycles after the grant.
REQ-031 Scenario: req=11 held out of reset -> grant order 0,1,0,1, with each done pulse preceding the next grant by 1 cycle.
REQ-032 Scenario: req=10, drop req after 3 cycles -> the full pattern still plays and done[1] pulses at cycle 40.
REQ-033 Scenario: reset driven low at cycle 10 of PLAY -> all outputs 0 asynchronously, no done pulse; after release with req=01, a fresh grant occurs.
REQ-034 Scenario: change pat0 mid-PLAY -> LED continues to follow the latched pattern.
REQ-035 Scenario: pat=8'hFF, then pat=8'h00 -> LED constant high for 32 cycles, then constant low; busy high through both full transactions.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern arbiter: FSM encoding, default
// timing constants and the round-robin winner selection.
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam int DEF_DIV_COUNT = 5000;
   localparam int DEF_GAP_SLOTS = 2;
   localparam int PAT_W         = 8;

   // Returns the index of the requester to grant. A lone request always
   // wins; on a tie the requester that was not served last wins.
   function automatic logic pick_winner(input logic [1:0] req_vec, input logic last_id);
      if (req_vec == 2'b11) begin
         return ~last_id;
      end
      return req_vec[1];
   endfunction

endpackage

// File: rtl/slot_tick.sv
// Slot divider: counts 0..DIV_COUNT-1 while enabled and flags the final
// cycle of each slot with a one-cycle tick.
module slot_tick
   import led_pkg::*;
#(
   parameter int DIV_COUNT = DEF_DIV_COUNT
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int                CNT_W = $clog2(DIV_COUNT);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV_COUNT - 1);

   logic [CNT_W-1:0] count;

   assign tick = enable && (count == LAST);

   // Slot counter: held at zero when cleared, wraps after the last cycle.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/led_pattern_arbiter.sv
// Two requesters share one LED. The winner's 8-bit pattern is latched at
// grant and played MSB first, one bit per slot, followed by GAP_SLOTS dark
// slots; then done pulses and the grant is released.
// Handshake: req is a level; gnt rises on the edge the request is accepted
// and stays high until the edge that pulses done for that requester.
module led_pattern_arbiter
   import led_pkg::*;
#(
   parameter int DIV_COUNT = DEF_DIV_COUNT,
   parameter int GAP_SLOTS = DEF_GAP_SLOTS
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [PAT_W-1:0] pat0,
   input  logic [PAT_W-1:0] pat1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy,
   output logic             LED,
   output state_t           state_dbg
);

   state_t           state;
   state_t           state_nxt;
   logic [PAT_W-1:0] pattern_reg;
   logic [2:0]       slot_idx;
   logic [3:0]       gap_cnt;
   logic             cur_id;
   logic             rr_last;
   logic             slot_end;
   logic             win;

   assign win       = pick_winner(req, rr_last);
   assign busy      = (state != ST_IDLE);
   assign LED       = (state == ST_PLAY) && pattern_reg[slot_idx];
   assign state_dbg = state;

   slot_tick #(
      .DIV_COUNT (DIV_COUNT)
   ) u_slot_tick (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .clear    (state == ST_IDLE),
      .enable   (state != ST_IDLE),
      .tick     (slot_end)
   );

   // State register.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: grant on any request, leave PLAY after the index-0 slot,
   // leave GAP on the slot end that empties the gap counter.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req != 2'b00)                 state_nxt = ST_PLAY;
         ST_PLAY: if (slot_end && slot_idx == 3'd0) state_nxt = ST_GAP;
         ST_GAP:  if (slot_end && gap_cnt == 4'd1)  state_nxt = ST_IDLE;
         default:                                   state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: latch pattern and owner at grant, step slot index and gap
   // counter on slot ends, release grant and pulse done at the end.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         pattern_reg <= '0;
         slot_idx    <= '0;
         gap_cnt     <= '0;
         cur_id      <= 1'b0;
         rr_last     <= 1'b1;
         gnt         <= 2'b00;
         done        <= 2'b00;
      end else begin
         done <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  cur_id      <= win;
                  gnt         <= win ? 2'b10 : 2'b01;
                  pattern_reg <= win ? pat1 : pat0;
                  slot_idx    <= 3'd7;
               end
            end
            ST_PLAY: begin
               if (slot_end) begin
                  if (slot_idx == 3'd0) begin
                     gap_cnt <= 4'(GAP_SLOTS);
                  end else begin
                     slot_idx <= slot_idx - 3'd1;
                  end
               end
            end
            ST_GAP: begin
               if (slot_end) begin
                  gap_cnt <= gap_cnt - 4'd1;
                  if (gap_cnt == 4'd1) begin
                     done    <= cur_id ? 2'b10 : 2'b01;
                     gnt     <= 2'b00;
                     rr_last <= cur_id;
                  end
               end
            end
            default: begin
               gnt <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Bench for led_pattern_arbiter with DIV_COUNT=4, GAP_SLOTS=2.
// The reference model tracks each transaction as "cycles since grant":
// LED is bit (7 - t/DIV) of the latched pattern for the first 8 slots,
// dark afterwards, and the transaction ends (8+GAP)*DIV edges after grant.
module tb_led_pattern_arbiter;
   import led_pkg::*;

   localparam int DIV   = 4;
   localparam int GAP   = 2;
   localparam int PLAYC = 8 * DIV;
   localparam int TXN   = (8 + GAP) * DIV;

   logic       CLOCK_50;
   logic       reset;
   logic [1:0] req;
   logic [7:0] pat0;
   logic [7:0] pat1;
   logic [1:0] gnt;
   logic [1:0] done;
   logic       busy;
   logic       LED;
   state_t     state_dbg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state
   logic       m_busy;
   int         m_t;
   logic       m_last;
   logic       m_owner;
   logic [1:0] m_gnt;
   logic [1:0] m_done;
   logic [7:0] m_pat;
   int         m_done_cnt = 0;
   logic [1:0] exp_q[$];
   logic       mon_exp_led;
   logic [1:0] mon_prev_gnt = 2'b00;
   logic [1:0] mon_got;

   led_pattern_arbiter #(
      .DIV_COUNT (DIV),
      .GAP_SLOTS (GAP)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .req       (req),
      .pat0      (pat0),
      .pat1      (pat1),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .LED       (LED),
      .state_dbg (state_dbg)
   );

   // clock / reset block
   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time exceeded, want finish before 500000");
      $fatal(1);
   end

   // behavioural reference model
   always @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         m_busy = 1'b0;
         m_t    = 0;
         m_last = 1'b1;
         m_gnt  = 2'b00;
         m_done = 2'b00;
         m_pat  = 8'h00;
         exp_q.delete();
      end else begin
         m_done = 2'b00;
         if (m_busy) begin
            m_t = m_t + 1;
            if (m_t == TXN) begin
               m_busy     = 1'b0;
               m_done     = m_gnt;
               m_last     = m_owner;
               m_gnt      = 2'b00;
               m_done_cnt = m_done_cnt + 1;
            end
         end else if (req != 2'b00) begin
            m_owner = (req == 2'b11) ? ~m_last : req[1];
            m_gnt   = m_owner ? 2'b10 : 2'b01;
            m_pat   = m_owner ? pat1 : pat0;
            m_busy  = 1'b1;
            m_t     = 0;
            exp_q.push_back(m_gnt);
         end
      end
   end

   // per-cycle scoreboard against the model, plus grant-order queue
   always @(negedge CLOCK_50) begin
      mon_exp_led = (m_busy && m_t < PLAYC) ? m_pat[7 - m_t / DIV] : 1'b0;
      total = total + 4;
      if (gnt !== m_gnt) begin
         bad++; $display("FAIL mon_gnt @%0d: got %b want %b", cyc, gnt, m_gnt);
      end
      if (done !== m_done) begin
         bad++; $display("FAIL mon_done @%0d: got %b want %b", cyc, done, m_done);
      end
      if (busy !== m_busy) begin
         bad++; $display("FAIL mon_busy @%0d: got %b want %b", cyc, busy, m_busy);
      end
      if (LED !== mon_exp_led) begin
         bad++; $display("FAIL mon_led @%0d: got %b want %b", cyc, LED, mon_exp_led);
      end
      if (gnt != 2'b00 && mon_prev_gnt == 2'b00) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++; $display("FAIL sb_grant @%0d: got %b want none", cyc, gnt);
         end else begin
            mon_got = exp_q.pop_front();
            if (gnt !== mon_got) begin
               bad++; $display("FAIL sb_grant @%0d: got %b want %b", cyc, gnt, mon_got);
            end
         end
      end
      mon_prev_gnt = gnt;
   end

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < max_cyc) begin
         @(negedge CLOCK_50);
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; req = 2'b00; pat0 = 8'h00; pat1 = 8'h00;
      repeat (3) @(negedge CLOCK_50);
      total += 5;
      if (gnt !== 2'b00)       begin bad++; $display("FAIL rst_gnt: got %b want 00", gnt); end
      if (done !== 2'b00)      begin bad++; $display("FAIL rst_done: got %b want 00", done); end
      if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (LED !== 1'b0)        begin bad++; $display("FAIL rst_led: got %b want 0", LED); end
      if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", state_dbg, ST_IDLE); end
      #2 reset = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_req: busy=%b want 0", busy); end
   endtask

   task automatic test_single;
      logic [7:0] seq;
      int t0, lat;
      seq = 8'b1010_0001;
      lat = -1;
      pat0 = seq; req = 2'b01;
      @(negedge CLOCK_50);
      total++;
      if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b want 01", gnt); end
      t0 = cyc; req = 2'b00;
      for (int k = 0; k < 60; k++) begin
         if (k > 0) @(negedge CLOCK_50);
         if (done[0] === 1'b1) begin lat = cyc - t0; break; end
         if (k < TXN) begin
            total++;
            if (LED !== ((k < PLAYC) ? seq[7 - k / DIV] : 1'b0)) begin
               bad++; $display("FAIL single_led k=%0d: got %b want %b", k, LED,
                               (k < PLAYC) ? seq[7 - k / DIV] : 1'b0);
            end
         end
      end
      total++;
      if (lat != TXN) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, TXN); end
      wait_idle(10);
   endtask

   task automatic test_back_to_back;
      logic [1:0] order[4];
      logic [1:0] prev_g, prev_d;
      int n;
      order = '{2'b01, 2'b10, 2'b01, 2'b10};
      @(negedge CLOCK_50);
      reset = 1'b0; req = 2'b11;
      pat0 = 8'($urandom); pat1 = 8'($urandom);
      @(negedge CLOCK_50);
      #2 reset = 1'b1;
      n = 0; prev_g = 2'b00; prev_d = 2'b00;
      for (int c = 0; c < 200 && n < 4; c++) begin
         @(negedge CLOCK_50);
         if (gnt != 2'b00 && prev_g == 2'b00) begin
            total++;
            if (gnt !== order[n]) begin bad++; $display("FAIL b2b_order n=%0d: got %b want %b", n, gnt, order[n]); end
            if (n > 0) begin
               total++;
               if (prev_d == 2'b00) begin bad++; $display("FAIL b2b_done_before_grant n=%0d: got %b want nonzero", n, prev_d); end
            end
            n++;
         end
         prev_g = gnt; prev_d = done;
      end
      total++;
      if (n != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", n); end
      req = 2'b00;
      wait_idle(60);
   endtask

   task automatic test_drop;
      int t0, lat;
      lat = -1;
      @(negedge CLOCK_50);
      pat1 = 8'($urandom); req = 2'b10;
      @(negedge CLOCK_50);
      total++;
      if (gnt !== 2'b10) begin bad++; $display("FAIL drop_gnt: got %b want 10", gnt); end
      t0 = cyc;
      repeat (2) @(negedge CLOCK_50);
      req = 2'b00;
      for (int k = 0; k < 60; k++) begin
         @(negedge CLOCK_50);
         if (done[1] === 1'b1) begin lat = cyc - t0; break; end
      end
      total++;
      if (lat != TXN) begin bad++; $display("FAIL drop_latency: got %0d want %0d", lat, TXN); end
      wait_idle(10);
   endtask

   task automatic test_pat_change;
      logic [7:0] orig;
      int chg;
      orig = 8'($urandom);
      chg  = $urandom_range(4, 28);
      @(negedge CLOCK_50);
      pat0 = orig; req = 2'b01;
      @(negedge CLOCK_50);
      req = 2'b00;
      for (int k = 1; k < PLAYC; k++) begin
         @(negedge CLOCK_50);
         if (k == chg) pat0 = ~orig;
         total++;
         if (LED !== orig[7 - k / DIV]) begin
            bad++; $display("FAIL patchg_led k=%0d: got %b want %b", k, LED, orig[7 - k / DIV]);
         end
      end
      wait_idle(20);
   endtask

   task automatic test_ff_00;
      @(negedge CLOCK_50);
      pat0 = 8'hFF; req = 2'b01;
      @(negedge CLOCK_50);
      pat0 = 8'h00;
      for (int k = 0; k <= 2 * TXN; k++) begin
         if (k > 0) @(negedge CLOCK_50);
         total += 2;
         if (busy !== (k != TXN)) begin
            bad++; $display("FAIL ff00_busy k=%0d: got %b want %b", k, busy, (k != TXN));
         end
         if (LED !== (k < PLAYC)) begin
            bad++; $display("FAIL ff00_led k=%0d: got %b want %b", k, LED, (k < PLAYC));
         end
      end
      req = 2'b00;
      wait_idle(60);
   endtask

   task automatic test_abort_reset;
      @(negedge CLOCK_50);
      pat0 = 8'($urandom) | 8'h80; req = 2'b01;
      @(negedge CLOCK_50);
      req = 2'b00;
      repeat (10) @(negedge CLOCK_50);
      #2 reset = 1'b0;
      #1;
      total += 5;
      if (gnt !== 2'b00)  begin bad++; $display("FAIL abort_gnt: got %b want 00", gnt); end
      if (done !== 2'b00) begin bad++; $display("FAIL abort_done: got %b want 00", done); end
      if (busy !== 1'b0)  begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      if (LED !== 1'b0)   begin bad++; $display("FAIL abort_led: got %b want 0", LED); end
      if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL abort_state: got %0d want %0d", state_dbg, ST_IDLE); end
      req = 2'b01;
      @(negedge CLOCK_50);
      #2 reset = 1'b1;
      @(negedge CLOCK_50);
      total++;
      if (gnt !== 2'b01) begin bad++; $display("FAIL abort_regrant: got %b want 01", gnt); end
      req = 2'b00;
      wait_idle(60);
   endtask

   task automatic test_random;
      int dut_dones, start_cnt;
      dut_dones = 0;
      start_cnt = m_done_cnt;
      for (int c = 0; c < 600; c++) begin
         @(negedge CLOCK_50);
         if (done != 2'b00) dut_dones++;
         if ($urandom_range(0, 9) == 0) req = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) pat0 = 8'($urandom);
         if ($urandom_range(0, 3) == 0) pat1 = 8'($urandom);
      end
      req = 2'b00;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLOCK_50);
         if (done != 2'b00) dut_dones++;
      end
      total++;
      if (dut_dones != m_done_cnt - start_cnt) begin
         bad++; $display("FAIL rand_done_count: got %0d want %0d", dut_dones, m_done_cnt - start_cnt);
      end
      wait_idle(5);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_drop();
      test_pat_change();
      test_ff_00();
      test_abort_reset();
      test_random();
      @(negedge CLOCK_50);
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL sb_leftover: got %0d pending grants want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
